// File: rtl/hex_entry_pkg.sv
// Shared constants and types for the push-button hex entry block.
package hex_entry_pkg;

    localparam int NUM_PB    = 4;
    localparam int PB_INC    = 0;
    localparam int PB_DEC    = 1;
    localparam int PB_CUR    = 2;
    localparam int PB_COMMIT = 3;

    typedef enum logic {IDLE = 1'b0, EDIT = 1'b1} entry_state_t;

    // Plain-vector encodings of the FSM states for legacy-compatible code
    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_EDIT = 1'(EDIT);

    // Cursor width; a single-digit build still gets a 1-bit cursor
    function automatic int cursor_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_entry_if.sv
// Button/load inputs and display-side outputs of hex_entry.
interface hex_entry_if
    import hex_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 6
);
    localparam int CW = cursor_w(NUM_DIGITS);

    logic [NUM_PB-1:0]         PB_sync;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_value;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      commit;
    logic [NUM_DIGITS-1:0]     en_mask;
    logic [CW-1:0]             cursor;
    logic                      editing;

    modport slave (
        input  PB_sync, load, load_value,
        output value, commit, en_mask, cursor, editing
    );

    modport master (
        output PB_sync, load, load_value,
        input  value, commit, en_mask, cursor, editing
    );
endinterface

// File: rtl/hex_entry_debounce.sv
// Single-button debouncer: accepts a level change only after
// DEBOUNCE_CYCLES consecutive differing samples; pulses on accepted presses.
module pb_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic pressed,
    output logic stable,
    output logic press_pulse
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] count;

    // Count differing samples; flip the stable level when the run is long enough
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stable      <= 1'b0;
            count       <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (pressed != stable) begin
                if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable      <= pressed;
                    count       <= '0;
                    press_pulse <= pressed;   // only the release->press edge is an event
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end
endmodule

// File: rtl/hex_entry.sv
// Push-button hex number entry: debounced buttons edit a NUM_DIGITS hex
// value digit by digit; committed value and blinking-cursor enable mask out.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int NUM_DIGITS      = 6,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 6250000,
    parameter int TIMEOUT_CYCLES  = 2**28
) (
    input  logic       CLK,
    input  logic       RST,
    hex_entry_if.slave bus
);
    localparam int CW  = cursor_w(NUM_DIGITS);
    localparam int VW  = 4 * NUM_DIGITS;
    localparam int BW  = $clog2(BLINK_CYCLES);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);

    logic [NUM_PB-1:0] pulse;
    logic [NUM_PB-1:0] unused_stable;

    logic [0:0]      state;
    logic [VW-1:0]   value_q;
    logic [VW-1:0]   edit_q;
    logic [CW-1:0]   cursor_q;
    logic            commit_q;
    logic            phase;
    logic [BW-1:0]   blink_cnt;
    logic [TW-1:0]   tmo_cnt;

    logic any_ev, act_commit, act_inc, act_dec, act_cur;
    logic [NUM_DIGITS-1:0] mask;

    for (genvar g = 0; g < NUM_PB; g++) begin : g_db
        pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .CLK         (CLK),
            .RST         (RST),
            .pressed     (~bus.PB_sync[g]),
            .stable      (unused_stable[g]),
            .press_pulse (pulse[g])
        );
    end

    // Resolve simultaneous events: commit > inc > dec > cursor
    always_comb begin
        any_ev     = |pulse;
        act_commit = pulse[PB_COMMIT];
        act_inc    = !pulse[PB_COMMIT] && pulse[PB_INC];
        act_dec    = !pulse[PB_COMMIT] && !pulse[PB_INC] && pulse[PB_DEC];
        act_cur    = !pulse[PB_COMMIT] && !pulse[PB_INC] && !pulse[PB_DEC] && pulse[PB_CUR];
    end

    // Entry FSM, digit editing, blink and timeout counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            value_q   <= '0;
            edit_q    <= '0;
            cursor_q  <= '0;
            commit_q  <= 1'b0;
            phase     <= 1'b1;
            blink_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            commit_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    phase     <= 1'b1;
                    blink_cnt <= '0;
                    tmo_cnt   <= '0;
                    // Wake press: enter EDIT on a copy of the committed value, no action
                    if (any_ev) begin
                        state    <= ST_EDIT;
                        edit_q   <= value_q;
                        cursor_q <= '0;
                    end
                end
                default: begin
                    if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                        phase     <= ~phase;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end

                    if (any_ev) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= ST_IDLE;      // abandon edits, value untouched
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end

                    if (act_commit) begin
                        value_q  <= edit_q;      // pre-load edit even if load is high
                        commit_q <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (!bus.load) begin
                        // Nibble arithmetic stays inside the digit: no carry/borrow
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (cursor_q == CW'(i)) begin
                                if (act_inc) edit_q[4*i +: 4] <= edit_q[4*i +: 4] + 4'd1;
                                if (act_dec) edit_q[4*i +: 4] <= edit_q[4*i +: 4] - 4'd1;
                            end
                        end
                        if (act_cur) begin
                            cursor_q  <= (cursor_q == CW'(NUM_DIGITS - 1)) ? '0 : cursor_q + 1'b1;
                            phase     <= 1'b1;
                            blink_cnt <= '0;
                        end
                    end
                end
            endcase
            // Load overrides any edit written above in the same cycle
            if (bus.load) edit_q <= bus.load_value;
        end
    end

    // Cursor digit follows the blink phase while editing; all digits lit otherwise
    always_comb begin
        mask = '1;
        if (state == ST_EDIT) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cursor_q == CW'(i)) mask[i] = phase;
            end
        end
    end

    assign bus.value   = value_q;
    assign bus.commit  = commit_q;
    assign bus.en_mask = mask;
    assign bus.cursor  = cursor_q;
    assign bus.editing = (state == ST_EDIT);

endmodule

// File: tb/tb_hex_entry.sv
// Directed bench for hex_entry with short debounce/blink/timeout constants.
module tb_hex_entry;
    localparam int ND = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   commits = 0;

    hex_entry_if #(.NUM_DIGITS(ND)) bus ();

    hex_entry #(
        .NUM_DIGITS      (ND),
        .DEBOUNCE_CYCLES (4),
        .BLINK_CYCLES    (8),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Commit pulses, sampled mid-cycle
    always @(negedge clk) if (bus.commit) commits++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the buttons in mask low for n cycles, then release and let it settle
    task automatic press_mask(input logic [3:0] mask, input int n);
        bus.PB_sync = ~mask;
        step(n);
        bus.PB_sync = 4'hF;
        step(8);
    endtask

    task automatic press(input int b, input int n);
        logic [3:0] m;
        m = 4'b0001 << b;
        press_mask(m, n);
    endtask

    initial begin
        int n;
        bus.PB_sync    = 4'hF;
        bus.load       = 1'b0;
        bus.load_value = '0;
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state
        chk("rst_value",   32'(bus.value),   32'h0);
        chk("rst_en_mask", 32'(bus.en_mask), 32'h3F);
        chk("rst_editing", 32'(bus.editing), 32'h0);
        chk("rst_cursor",  32'(bus.cursor),  32'h0);

        // Idle buttons do nothing
        step(100);
        chk("idle_commits", 32'(commits),     32'h0);
        chk("idle_editing", 32'(bus.editing), 32'h0);

        // Short glitch rejected; long press wakes once
        press(0, 2);
        chk("glitch_editing", 32'(bus.editing), 32'h0);
        press(0, 10);
        chk("wake_editing", 32'(bus.editing), 32'h1);
        chk("wake_cursor",  32'(bus.cursor),  32'h0);
        chk("wake_value",   32'(bus.value),   32'h0);

        // 3x inc, cursor, 2x dec, commit -> E3
        repeat (3) press(0, 6);
        press(2, 6);
        chk("cursor_one", 32'(bus.cursor), 32'h1);
        repeat (2) press(1, 6);
        press(3, 6);
        chk("commit_value",   32'(bus.value),   32'h0000E3);
        chk("commit_count",   32'(commits),     32'h1);
        chk("commit_editing", 32'(bus.editing), 32'h0);

        // Cursor wrap and blink period
        press(2, 6);
        repeat (6) press(2, 6);
        chk("wrap_cursor", 32'(bus.cursor), 32'h0);
        n = 0;
        while (bus.en_mask != 6'h3F && n < 40) begin step(1); n++; end
        n = 0;
        while (bus.en_mask == 6'h3F && n < 40) begin step(1); n++; end
        chk("blink_low_mask", 32'(bus.en_mask), 32'h3E);
        n = 0;
        while (bus.en_mask == 6'h3E && n < 40) begin step(1); n++; end
        chk("blink_low_len", 32'(n), 32'd8);
        chk("blink_high_mask", 32'(bus.en_mask), 32'h3F);

        // Edit then abandon via timeout
        press(0, 6);
        step(30);
        chk("tmo_still_edit", 32'(bus.editing), 32'h1);
        step(40);
        chk("tmo_editing", 32'(bus.editing), 32'h0);
        chk("tmo_value",   32'(bus.value),   32'h0000E3);
        chk("tmo_commits", 32'(commits),     32'h1);

        // Simultaneous inc+commit: commit only
        press(1, 6);
        press(0, 6);
        press_mask(4'b1001, 6);
        chk("both_value",   32'(bus.value),   32'h0000E4);
        chk("both_commits", 32'(commits),     32'h2);
        chk("both_editing", 32'(bus.editing), 32'h0);

        // Load in the same cycle as an inc event: load wins
        press(2, 6);
        bus.load_value = 24'h123456;
        bus.PB_sync    = 4'b1110;
        step(4);
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(1);
        bus.PB_sync = 4'hF;
        step(8);
        chk("load_editing", 32'(bus.editing), 32'h1);
        press(3, 6);
        chk("load_value", 32'(bus.value), 32'h123456);
        chk("load_commits", 32'(commits), 32'h3);

        // Async reset mid-edit, between clock edges
        press(0, 6);
        press(0, 6);
        chk("pre_rst_editing", 32'(bus.editing), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_value",   32'(bus.value),   32'h0);
        chk("arst_editing", 32'(bus.editing), 32'h0);
        chk("arst_en_mask", 32'(bus.en_mask), 32'h3F);
        chk("arst_cursor",  32'(bus.cursor),  32'h0);
        chk("arst_commit",  32'(bus.commit),  32'h0);
        step(2);
        rst = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
